stack_unit: RTL and testbench

//  Parametrised LIFO stack: successor to the fixed 32x64 stack pointer block.

---
 rtl/stack_unit_if.sv | 32 +++
 rtl/stack_unit.sv | 97 +++++++++
 tb/tb_stack_unit.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/stack_unit_if.sv
// rtl/stack_unit_if.sv - stack operation and status bus between a controller and stack_unit
interface stack_unit_if #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 64
);
   localparam int PTR_W = $clog2(DEPTH + 1);

   logic              enable;
   logic              push;
   logic              pop;
   logic [DATA_W-1:0] data_in;
   logic [PTR_W-1:0]  peek_idx;
   logic              err_clr;
   logic [DATA_W-1:0] data_out;
   logic [DATA_W-1:0] peek_data;
   logic              peek_valid;
   logic [PTR_W-1:0]  count;
   logic              empty;
   logic              full;
   logic              overflow;
   logic              underflow;

   modport master (
      output enable, push, pop, data_in, peek_idx, err_clr,
      input  data_out, peek_data, peek_valid, count, empty, full, overflow, underflow
   );

   modport slave (
      input  enable, push, pop, data_in, peek_idx, err_clr,
      output data_out, peek_data, peek_valid, count, empty, full, overflow, underflow
   );
endinterface

// File: rtl/stack_unit.sv
// rtl/stack_unit.sv - parametrised LIFO stack with peek, occupancy and sticky error flags
module stack_unit #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 64
) (
   input  logic         clk,
   input  logic         rst,
   stack_unit_if.slave  bus
);
   localparam int PTR_W = $clog2(DEPTH + 1);
   localparam int AW    = $clog2(DEPTH);

   logic [PTR_W-1:0]  sp_q, sp_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              is_empty;
   logic              is_full;
   logic              do_push;
   logic              do_pop;
   logic [PTR_W-1:0]  top_ptr;
   logic [PTR_W-1:0]  peek_ptr;
   logic              wr_en;
   logic [AW-1:0]     wr_addr;

   // Occupancy decode and read-side address arithmetic shared by both outputs and next-state
   always_comb begin
      is_empty = (sp_q == '0);
      is_full  = (sp_q == PTR_W'(DEPTH));
      do_push  = bus.enable & bus.push;
      do_pop   = bus.enable & bus.pop;
      top_ptr  = sp_q - PTR_W'(1);
      peek_ptr = top_ptr - bus.peek_idx;
   end

   // Next-state: pointer moves, array write strobe and sticky flags (a new error beats err_clr)
   always_comb begin
      sp_d        = sp_q;
      overflow_d  = overflow_q & ~bus.err_clr;
      underflow_d = underflow_q & ~bus.err_clr;
      wr_en       = 1'b0;
      wr_addr     = '0;
      if (do_push && do_pop && !is_empty) begin
         // Replace top in place; legal even when full since occupancy does not change
         wr_en   = 1'b1;
         wr_addr = top_ptr[AW-1:0];
      end else if (do_push) begin
         // Also covers push+pop on an empty stack, which behaves as a plain push
         if (is_full) begin
            overflow_d = 1'b1;
         end else begin
            wr_en   = 1'b1;
            wr_addr = sp_q[AW-1:0];
            sp_d    = sp_q + PTR_W'(1);
         end
      end else if (do_pop) begin
         if (is_empty) begin
            underflow_d = 1'b1;
         end else begin
            sp_d = top_ptr;
         end
      end
   end

   // Stack pointer and error flags; reset empties the stack and drops any pending push
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sp_q        <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         sp_q        <= sp_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Entry storage is not reset; stale entries are never visible because reads are gated by sp
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= bus.data_in;
      end
   end

   // Combinational read of top and peek entries, forced to zero when not backed by a valid entry
   always_comb begin
      bus.count      = sp_q;
      bus.empty      = is_empty;
      bus.full       = is_full;
      bus.overflow   = overflow_q;
      bus.underflow  = underflow_q;
      bus.peek_valid = (bus.peek_idx < sp_q);
      bus.data_out   = is_empty ? '0 : mem_q[top_ptr[AW-1:0]];
      bus.peek_data  = bus.peek_valid ? mem_q[peek_ptr[AW-1:0]] : '0;
   end
endmodule

// File: tb/tb_stack_unit.sv
// tb/tb_stack_unit.sv - directed self-checking bench for stack_unit
module tb_stack_unit;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 4;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   stack_unit_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

   stack_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst_n),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // One clock with the given controls, then return inputs to idle away from the edge
   task automatic step(input logic en, input logic pu, input logic po,
                       input logic [DATA_W-1:0] d, input logic clr);
      bus.enable  = en;
      bus.push    = pu;
      bus.pop     = po;
      bus.data_in = d;
      bus.err_clr = clr;
      @(posedge clk);
      #1;
      bus.enable  = 1'b0;
      bus.push    = 1'b0;
      bus.pop     = 1'b0;
      bus.data_in = '0;
      bus.err_clr = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus.enable   = 1'b0;
      bus.push     = 1'b0;
      bus.pop      = 1'b0;
      bus.data_in  = '0;
      bus.peek_idx = '0;
      bus.err_clr  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_count", 32'(bus.count), 0);
      check("rst_empty", 32'(bus.empty), 1);
      check("rst_full", 32'(bus.full), 0);
      check("rst_dout", bus.data_out, 0);
      check("rst_pvalid", 32'(bus.peek_valid), 0);
      check("rst_pdata", bus.peek_data, 0);
      check("rst_flags", {30'd0, bus.overflow, bus.underflow}, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Push A, B, C and peek below top
      step(1, 1, 0, 32'hA, 0);
      step(1, 1, 0, 32'hB, 0);
      step(1, 1, 0, 32'hC, 0);
      check("abc_dout", bus.data_out, 32'hC);
      check("abc_count", 32'(bus.count), 3);
      bus.peek_idx = 3'd2;
      #1;
      check("peek2_data", bus.peek_data, 32'hA);
      check("peek2_valid", 32'(bus.peek_valid), 1);
      bus.peek_idx = 3'd1;
      #1;
      check("peek1_data", bus.peek_data, 32'hB);
      bus.peek_idx = 3'd3;
      #1;
      check("peek3_data", bus.peek_data, 0);
      check("peek3_valid", 32'(bus.peek_valid), 0);
      bus.peek_idx = 3'd0;

      // Async reset mid-cycle with a push pending: must be discarded
      bus.enable  = 1'b1;
      bus.push    = 1'b1;
      bus.data_in = 32'hEE;
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_count_async", 32'(bus.count), 0);
      check("arst_dout_async", bus.data_out, 0);
      @(posedge clk);
      #1;
      bus.enable = 1'b0;
      bus.push   = 1'b0;
      rst_n      = 1'b1;
      @(posedge clk);
      #1;
      check("arst_count", 32'(bus.count), 0);
      check("arst_empty", 32'(bus.empty), 1);
      check("arst_full", 32'(bus.full), 0);
      check("arst_dout", bus.data_out, 0);
      check("arst_flags", {30'd0, bus.overflow, bus.underflow}, 0);

      // Fill to DEPTH, overflow, replace-top while full
      for (int i = 1; i <= DEPTH; i++) step(1, 1, 0, DATA_W'(i), 0);
      check("fill_full", 32'(bus.full), 1);
      check("fill_count", 32'(bus.count), 4);
      check("fill_dout", bus.data_out, 4);
      step(1, 1, 0, 32'h5, 0);
      check("ovf_flag", 32'(bus.overflow), 1);
      check("ovf_count", 32'(bus.count), 4);
      check("ovf_dout", bus.data_out, 4);
      step(1, 1, 1, 32'h9, 0);
      check("repl_dout", bus.data_out, 32'h9);
      check("repl_count", 32'(bus.count), 4);
      check("repl_full", 32'(bus.full), 1);
      bus.peek_idx = 3'd1;
      #1;
      check("repl_peek1", bus.peek_data, 3);
      bus.peek_idx = 3'd0;
      step(1, 0, 1, 0, 0);
      check("pop_dout", bus.data_out, 3);
      check("pop_count", 32'(bus.count), 3);
      check("pop_full", 32'(bus.full), 0);
      check("ovf_sticky", 32'(bus.overflow), 1);
      step(0, 0, 0, 0, 1);
      check("ovf_clr", 32'(bus.overflow), 0);

      // Drain, then underflow and err_clr priority
      for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0);
      check("drain_count", 32'(bus.count), 0);
      check("drain_dout", bus.data_out, 0);
      check("drain_uf", 32'(bus.underflow), 0);
      step(1, 0, 1, 0, 0);
      check("uf_flag", 32'(bus.underflow), 1);
      check("uf_count", 32'(bus.count), 0);
      step(0, 0, 0, 0, 1);
      check("uf_clr", 32'(bus.underflow), 0);
      step(1, 0, 1, 0, 1);
      check("uf_clr_prio", 32'(bus.underflow), 1);
      step(0, 0, 0, 0, 1);

      // Push+pop on empty acts as push
      step(1, 1, 1, 32'h55, 0);
      check("pp_empty_count", 32'(bus.count), 1);
      check("pp_empty_dout", bus.data_out, 32'h55);
      check("pp_empty_uf", 32'(bus.underflow), 0);

      // Disabled: push/pop ignored for several cycles
      for (int i = 0; i < 3; i++) step(0, 1, 1, 32'h77, 0);
      check("dis_count", 32'(bus.count), 1);
      check("dis_dout", bus.data_out, 32'h55);
      check("dis_flags", {30'd0, bus.overflow, bus.underflow}, 0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      check("dis_pop_count", 32'(bus.count), 1);
      check("dis_pop_uf", 32'(bus.underflow), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
